// File: rtl/gyro_sample_scheduler_pkg.sv
// Shared definitions for the gyro sample scheduler: gyro register map,
// burst length, FSM state encodings and the published rate sample type.
package gyro_pkg;

   localparam logic [7:0]  CTRL_REG1  = 8'h20;
   localparam logic [7:0]  OUT_X_L    = 8'h28;
   localparam logic [7:0]  READ_FLAG  = 8'h80;
   localparam int unsigned BYTE_COUNT = 6;

   typedef logic [2:0] state_t;
   typedef logic [2:0] byte_idx_t;

   localparam state_t ST_CFG_ISSUE = 3'd0;
   localparam state_t ST_CFG_WAIT  = 3'd1;
   localparam state_t ST_WAIT_TICK = 3'd2;
   localparam state_t ST_RD_ISSUE  = 3'd3;
   localparam state_t ST_RD_WAIT   = 3'd4;
   localparam state_t ST_PUBLISH   = 3'd5;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } rate_t;

   // Burst read address for one output byte: read flag plus register offset.
   function automatic logic [7:0] rd_addr(input logic [7:0] base, input byte_idx_t idx);
      return READ_FLAG | (base + {5'd0, idx});
   endfunction

endpackage

// File: rtl/gyro_sample_scheduler_if.sv
// Handshake to the shared SPI master.
//   spi_busy  : transaction in progress (from SPI master)
//   spi_done  : one-cycle completion pulse, spi_rdata valid
//   spi_rdata : read byte
//   spi_start : one-cycle transaction request
//   spi_rw    : 1 = read, 0 = write
//   spi_addr  : register address, bit 7 = read flag
//   spi_wdata : write byte
interface gyro_sample_scheduler_if;
   logic       spi_busy;
   logic       spi_done;
   logic [7:0] spi_rdata;
   logic       spi_start;
   logic       spi_rw;
   logic [7:0] spi_addr;
   logic [7:0] spi_wdata;

   modport master (
      input  spi_busy, spi_done, spi_rdata,
      output spi_start, spi_rw, spi_addr, spi_wdata
   );

   modport slave (
      output spi_busy, spi_done, spi_rdata,
      input  spi_start, spi_rw, spi_addr, spi_wdata
   );
endinterface

// File: rtl/gyro_sample_scheduler_tick_gen.sv
// Free-running sample period counter, 0..DIV-1, with a one-cycle tick on
// the cycle it wraps. Reusable by any periodically sampled peripheral.
//   clk          : system clock
//   system_reset : synchronous active-high reset
//   tick_o       : high for the single cycle in which the counter wraps
module sample_tick_gen #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic system_reset,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gyro_sample_scheduler.sv
// Gyro sample scheduler: writes CTRL_REG1 once after reset, then on every
// sample tick burst-reads OUT_X_L..OUT_Z_H through the shared SPI master and
// publishes the three 16-bit rates with a one-cycle rate_valid strobe.
// Host angle-reset requests are delivered on the publish cycle; ticks lost
// while a read is still running are counted in overrun_count (saturating).
//   clk, system_reset   : clock, synchronous active-high reset
//   spi                 : SPI master handshake (master side)
//   angle_reset_req     : host request, level or pulse
//   angular_rate_x/y/z  : published rates
//   rate_valid          : one-cycle new-sample strobe
//   angle_reset         : one-cycle integrator reset, coincident with rate_valid
//   configured          : configuration write completed
//   overrun_count       : dropped ticks, saturates at 255
//
// state        | meaning
// CFG_ISSUE    | wait for SPI idle, request CTRL_REG1 write
// CFG_WAIT     | wait for config write to complete
// WAIT_TICK    | idle until the next sample tick
// RD_ISSUE     | wait for SPI idle, request read of byte[idx]
// RD_WAIT      | wait for read data, store into shadow byte[idx]
// PUBLISH      | copy shadow bytes to outputs, strobe rate_valid
module gyro_sample_scheduler import gyro_pkg::*; #(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter logic [7:0]  CFG_ADDR   = CTRL_REG1,
   parameter logic [7:0]  CFG_DATA   = 8'h0F,
   parameter logic [7:0]  OUT_BASE   = OUT_X_L
) (
   input  logic                           clk,
   input  logic                           system_reset,
   gyro_sample_scheduler_if.master        spi,
   input  logic                           angle_reset_req,
   output logic [15:0]                    angular_rate_x,
   output logic [15:0]                    angular_rate_y,
   output logic [15:0]                    angular_rate_z,
   output logic                           rate_valid,
   output logic                           angle_reset,
   output logic                           configured,
   output logic [7:0]                     overrun_count
);

   localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTE_COUNT - 1);

   logic       tick;
   state_t     state_q, state_d;
   byte_idx_t  idx_q, idx_d;
   logic [7:0] shadow_q [BYTE_COUNT];
   logic [7:0] shadow_d [BYTE_COUNT];
   rate_t      rate_q, rate_d;
   logic       valid_q, valid_d;
   logic       ar_q, ar_d;
   logic       cfgd_q, cfgd_d;
   logic [7:0] ovr_q, ovr_d;
   logic       start_q, start_d;
   logic       rw_q, rw_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       req_q, req_d;
   logic       pend_q, pend_d;
   logic       req_edge;
   logic       in_read;

   sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
      .clk          (clk),
      .system_reset (system_reset),
      .tick_o       (tick)
   );

   assign req_edge = angle_reset_req & ~req_q;
   assign in_read  = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT) ||
                     (state_q == ST_PUBLISH);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      rate_d   = rate_q;
      valid_d  = 1'b0;
      ar_d     = 1'b0;
      cfgd_d   = cfgd_q;
      ovr_d    = ovr_q;
      start_d  = 1'b0;
      rw_d     = rw_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      req_d    = angle_reset_req;
      pend_d   = pend_q | req_edge;

      case (state_q)
         ST_CFG_ISSUE: begin
            if (!spi.spi_busy) begin
               start_d = 1'b1;
               rw_d    = 1'b0;
               addr_d  = CFG_ADDR;
               wdata_d = CFG_DATA;
               state_d = ST_CFG_WAIT;
            end
         end
         ST_CFG_WAIT: begin
            if (spi.spi_done) begin
               cfgd_d  = 1'b1;
               state_d = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (tick) begin
               idx_d   = '0;
               state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            if (!spi.spi_busy) begin
               start_d = 1'b1;
               rw_d    = 1'b1;
               addr_d  = rd_addr(OUT_BASE, idx_q);
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (spi.spi_done) begin
               shadow_d[idx_q] = spi.spi_rdata;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_PUBLISH;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_RD_ISSUE;
               end
            end
         end
         ST_PUBLISH: begin
            rate_d.x = {shadow_q[1], shadow_q[0]};
            rate_d.y = {shadow_q[3], shadow_q[2]};
            rate_d.z = {shadow_q[5], shadow_q[4]};
            valid_d  = 1'b1;
            if (pend_q) begin
               ar_d   = 1'b1;
               // A request edge landing on the delivery cycle stays pending.
               pend_d = req_edge;
            end
            state_d = ST_WAIT_TICK;
         end
         default: state_d = ST_CFG_ISSUE;
      endcase

      if (tick && in_read && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         state_q  <= ST_CFG_ISSUE;
         idx_q    <= '0;
         shadow_q <= '{default: 8'h00};
         rate_q   <= '0;
         valid_q  <= 1'b0;
         ar_q     <= 1'b0;
         cfgd_q   <= 1'b0;
         ovr_q    <= '0;
         start_q  <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         req_q    <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         rate_q   <= rate_d;
         valid_q  <= valid_d;
         ar_q     <= ar_d;
         cfgd_q   <= cfgd_d;
         ovr_q    <= ovr_d;
         start_q  <= start_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         req_q    <= req_d;
         pend_q   <= pend_d;
      end
   end

   assign spi.spi_start   = start_q;
   assign spi.spi_rw      = rw_q;
   assign spi.spi_addr    = addr_q;
   assign spi.spi_wdata   = wdata_q;
   assign angular_rate_x  = rate_q.x;
   assign angular_rate_y  = rate_q.y;
   assign angular_rate_z  = rate_q.z;
   assign rate_valid      = valid_q;
   assign angle_reset     = ar_q;
   assign configured      = cfgd_q;
   assign overrun_count   = ovr_q;

endmodule
